// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder definitions: block size, zigzag-to-raster table and bank states.
package jpeg_enc_pkg;

  localparam int unsigned BLOCK_PIXELS = 64;

  // ZIGZAG[k] is the raster position (row*8 + col) of the k-th coefficient in zigzag order.
  localparam logic [5:0] ZIGZAG [BLOCK_PIXELS] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull
  } bank_state_e;

  // Derive a bank's state from its full flag and whether it is the current write target.
  function automatic bank_state_e bank_state(input logic full, input logic is_target);
    if (full) begin
      return BankFull;
    end else if (is_target) begin
      return BankFilling;
    end
    return BankEmpty;
  endfunction

endpackage

// File: rtl/pingpong_blockbuffer_if.sv
// Pixel-in / block-out handshake bundle for the ping-pong block buffer.
interface pingpong_blockbuffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH*DEPTH-1:0] out_block;
  logic [1:0]                  blocks_avail;
  logic [IdxW-1:0]             wr_index;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_block, blocks_avail, wr_index
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_block, blocks_avail, wr_index
  );
endinterface

// File: rtl/blockbuffer_bank.sv
// One block of pixel storage: synchronous write port, whole block visible as a packed word
// with element 0 in the MSBs.
module blockbuffer_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned AddrW     = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        we_i,
  input  logic [AddrW-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  output logic [DATA_WIDTH*DEPTH-1:0] block_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next storage contents: one pixel replaced on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Storage register; reset clears every pixel so the output reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Pack element 0 into the most significant slot.
  always_comb begin
    block_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      block_o[(int'(DEPTH) - 1 - i) * int'(DATA_WIDTH) +: DATA_WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/pingpong_blockbuffer.sv
// Two-bank ping-pong block buffer: pixels stream into one bank while the other is offered as
// a complete packed block. Define PINGPONG_ZIGZAG_WRITE_EN to scatter a zigzag-ordered input
// stream into raster order (requires DEPTH == 64).
module pingpong_blockbuffer
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  pingpong_blockbuffer_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned BlkW = DATA_WIDTH * DEPTH;

  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      full_q, full_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [IdxW-1:0] wr_addr;
  logic            wr_en, rd_en, last_px;
  bank_state_e     wr_state;
  logic [BlkW-1:0] bank_block [2];

`ifdef PINGPONG_ZIGZAG_WRITE_EN
  if (DEPTH != BLOCK_PIXELS) begin : g_depth_check
    $error("pingpong_blockbuffer: zigzag write order needs DEPTH == 64");
  end

  // Zigzag stream position -> raster slot.
  always_comb begin
    wr_addr = IdxW'(ZIGZAG[wr_idx_q]);
  end
`else
  // Raster order: slot equals stream position.
  always_comb begin
    wr_addr = wr_idx_q;
  end
`endif

  // Handshakes; a write is refused while the write target still holds an unread block.
  always_comb begin
    wr_state     = bank_state(full_q[wbank_q], 1'b1);
    bus.in_ready = (wr_state != BankFull) && !bus.flush && !reset;
    wr_en        = bus.in_valid && bus.in_ready;
    rd_en        = full_q[rbank_q] && bus.out_ready;
    last_px      = (wr_idx_q == IdxW'(DEPTH - 1));
  end

  // Pointer and flag updates; a last-pixel write and a read never touch the same bank.
  always_comb begin
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    full_d   = full_q;
    wr_idx_d = wr_idx_q;
    if (bus.flush) begin
      wr_idx_d = '0;
    end else if (wr_en) begin
      if (last_px) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wr_idx_d        = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (rd_en) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  // Control registers; reset overrides flush, writes and reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
      wr_idx_q <= '0;
    end else begin
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    blockbuffer_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .we_i    (wr_en && (wbank_q == 1'(b))),
      .waddr_i (wr_addr),
      .wdata_i (bus.in_data),
      .block_o (bank_block[b])
    );
  end

  // Read side always shows the bank rbank points at.
  always_comb begin
    bus.out_valid    = full_q[rbank_q];
    bus.out_block    = bank_block[rbank_q];
    bus.blocks_avail = 2'(full_q[0]) + 2'(full_q[1]);
    bus.wr_index     = wr_idx_q;
  end

endmodule
